// File: rtl/p_to_s_pkg.sv
// Shared types for the parallel-to-serial converter: word type and FSM state encoding.
package p_to_s_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic {IDLE, SHIFT} state_t;

endpackage

// File: rtl/p_to_s_converter.sv
// Parallel-to-serial converter: latches a PARALLEL_LENGTH-word frame and emits it as
// SERIAL_LENGTH-word chunks with valid/ready on both sides. Define P_TO_S_REVERSE_EN to
// emit chunks highest index first.
module p_to_s_converter
  import p_to_s_pkg::*;
#(
  parameter int unsigned PARALLEL_LENGTH = 4,
  parameter int unsigned SERIAL_LENGTH   = 2
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     fct,
  input  logic                                     ien,
  output logic                                     iready,
  input  logic [0:PARALLEL_LENGTH-1][WORD_W-1:0]   idata,
  input  logic                                     oready,
  output logic                                     oen,
  output logic [0:SERIAL_LENGTH-1][WORD_W-1:0]     odata,
  output logic                                     finished
);

  localparam int NB_CHUNKS = (SERIAL_LENGTH == 0) ? 1 : int'(PARALLEL_LENGTH / SERIAL_LENGTH);
  localparam int SER_LEN   = int'(SERIAL_LENGTH);
  localparam int CNT_W     = (NB_CHUNKS > 1) ? $clog2(NB_CHUNKS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NB_CHUNKS - 1);

  if (SERIAL_LENGTH == 0) begin : g_bad_serial
    $error("SERIAL_LENGTH must be at least 1");
  end else if ((PARALLEL_LENGTH % SERIAL_LENGTH) != 0) begin : g_bad_ratio
    $error("PARALLEL_LENGTH must be a multiple of SERIAL_LENGTH");
  end

  state_t                                r_state;
  state_t                                w_state_next;
  logic [CNT_W-1:0]                      r_cnt;
  logic [CNT_W-1:0]                      w_cnt_next;
  logic [CNT_W-1:0]                      w_idx;
  logic [0:PARALLEL_LENGTH-1][WORD_W-1:0] r_buf;
  logic                                  w_last;
  logic                                  w_accept;
  logic                                  w_xfer;

  assign w_last   = (r_cnt == LAST_CNT);
  assign w_accept = fct & ien & iready;
  assign w_xfer   = oen & oready;

  // The counter always counts up; only the chunk it selects changes with the build.
`ifdef P_TO_S_REVERSE_EN
  assign w_idx = LAST_CNT - r_cnt;
`else
  assign w_idx = r_cnt;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_buf   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_buf <= idata;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    if (!fct) begin
      w_state_next = IDLE;
      w_cnt_next   = '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            w_state_next = SHIFT;
            w_cnt_next   = '0;
          end
        end
        SHIFT: begin
          if (w_xfer) begin
            if (w_last) begin
              // A same-cycle accept reloads the buffer and keeps shifting with no bubble.
              w_state_next = w_accept ? SHIFT : IDLE;
              w_cnt_next   = '0;
            end else begin
              w_cnt_next = r_cnt + CNT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    iready   = 1'b0;
    oen      = 1'b0;
    finished = 1'b0;
    odata    = '0;
    if (rst_n && fct) begin
      unique case (r_state)
        IDLE: iready = 1'b1;
        SHIFT: begin
          oen      = 1'b1;
          finished = w_last;
          iready   = oready & w_last;
          for (int c = 0; c < NB_CHUNKS; c++) begin
            if (w_idx == CNT_W'(c)) begin
              for (int i = 0; i < SER_LEN; i++) begin
                odata[i] = r_buf[c*SER_LEN+i];
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_p_to_s_converter.sv
// Directed bench for p_to_s_converter (PARALLEL_LENGTH=4, SERIAL_LENGTH=2); honours
// P_TO_S_REVERSE_EN for the expected chunk order.
module tb_p_to_s_converter;

  logic              clk;
  logic              rst_n;
  logic              fct;
  logic              ien;
  logic              iready;
  logic [0:3][31:0]  idata;
  logic              oready;
  logic              oen;
  logic [0:1][31:0]  odata;
  logic              finished;

  int checks;
  int failures;

  logic [0:3][31:0] f1;
  logic [0:3][31:0] f2;
  logic [66:0]      exp_v;
  logic [66:0]      obs_v;

  p_to_s_converter #(
    .PARALLEL_LENGTH(4),
    .SERIAL_LENGTH  (2)
  ) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .fct     (fct),
    .ien     (ien),
    .iready  (iready),
    .idata   (idata),
    .oready  (oready),
    .oen     (oen),
    .odata   (odata),
    .finished(finished)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Chunk emitted in position k (0 = first) of a frame.
  function automatic logic [0:1][31:0] chunk(input logic [0:3][31:0] f, input int k);
    logic [0:1][31:0] r;
    int idx;
`ifdef P_TO_S_REVERSE_EN
    idx = 1 - k;
`else
    idx = k;
`endif
    r[0] = f[2*idx];
    r[1] = f[2*idx+1];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fct = 1'b1; ien = 1'b0; oready = 1'b1; idata = '0;
    step();
    step();
    #1;
    obs_v = {oen, finished, iready, odata};
    exp_v = {3'b000, 64'h0};
    checks++;
    if (obs_v !== exp_v) begin
      failures++; $display("FAIL reset_outputs got=%h exp=%h", obs_v, exp_v);
    end
    rst_n = 1'b1;
    #1;
    obs_v = {oen, finished, iready, odata};
    exp_v = {3'b001, 64'h0};
    checks++;
    if (obs_v !== exp_v) begin
      failures++; $display("FAIL reset_release_idle got=%h exp=%h", obs_v, exp_v);
    end
  endtask

  task automatic test_basic();
    ien = 1'b1; idata = f1;
    #1;
    checks++;
    if (iready !== 1'b1) begin
      failures++; $display("FAIL basic_iready_idle got=%b exp=1", iready);
    end
    step();
    ien = 1'b0; idata = '0;
    #1;
    obs_v = {oen, finished, iready, odata};
    exp_v = {3'b100, chunk(f1, 0)};
    checks++;
    if (obs_v !== exp_v) begin
      failures++; $display("FAIL basic_chunk0 got=%h exp=%h", obs_v, exp_v);
    end
    step();
    #1;
    obs_v = {oen, finished, iready, odata};
    exp_v = {3'b111, chunk(f1, 1)};
    checks++;
    if (obs_v !== exp_v) begin
      failures++; $display("FAIL basic_chunk1 got=%h exp=%h", obs_v, exp_v);
    end
    step();
    #1;
    obs_v = {oen, finished, iready, odata};
    exp_v = {3'b001, 64'h0};
    checks++;
    if (obs_v !== exp_v) begin
      failures++; $display("FAIL basic_back_idle got=%h exp=%h", obs_v, exp_v);
    end
  endtask

  task automatic test_backpressure();
    ien = 1'b1; idata = f1;
    step();
    ien = 1'b0; idata = '0; oready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      #1;
      obs_v = {oen, finished, iready, odata};
      exp_v = {3'b100, chunk(f1, 0)};
      checks++;
      if (obs_v !== exp_v) begin
        failures++; $display("FAIL bp_hold_%0d got=%h exp=%h", n, obs_v, exp_v);
      end
      step();
    end
    oready = 1'b1;
    #1;
    obs_v = {oen, finished, iready, odata};
    exp_v = {3'b100, chunk(f1, 0)};
    checks++;
    if (obs_v !== exp_v) begin
      failures++; $display("FAIL bp_release_chunk0 got=%h exp=%h", obs_v, exp_v);
    end
    step();
    #1;
    obs_v = {oen, finished, iready, odata};
    exp_v = {3'b111, chunk(f1, 1)};
    checks++;
    if (obs_v !== exp_v) begin
      failures++; $display("FAIL bp_chunk1 got=%h exp=%h", obs_v, exp_v);
    end
    step();
  endtask

  task automatic test_back_to_back();
    ien = 1'b1; idata = f1;
    step();
    ien = 1'b0; idata = '0;
    step();
    ien = 1'b1; idata = f2;
    #1;
    obs_v = {oen, finished, iready, odata};
    exp_v = {3'b111, chunk(f1, 1)};
    checks++;
    if (obs_v !== exp_v) begin
      failures++; $display("FAIL b2b_last_iready got=%h exp=%h", obs_v, exp_v);
    end
    step();
    ien = 1'b0; idata = '0;
    #1;
    obs_v = {oen, finished, iready, odata};
    exp_v = {3'b100, chunk(f2, 0)};
    checks++;
    if (obs_v !== exp_v) begin
      failures++; $display("FAIL b2b_no_bubble got=%h exp=%h", obs_v, exp_v);
    end
    step();
    #1;
    obs_v = {oen, finished, iready, odata};
    exp_v = {3'b111, chunk(f2, 1)};
    checks++;
    if (obs_v !== exp_v) begin
      failures++; $display("FAIL b2b_f2_chunk1 got=%h exp=%h", obs_v, exp_v);
    end
    step();
    #1;
    checks++;
    if (oen !== 1'b0) begin
      failures++; $display("FAIL b2b_idle_after oen=%b exp=0", oen);
    end
  endtask

  task automatic test_ignored_ien();
    ien = 1'b1; idata = f1;
    step();
    idata = f2; oready = 1'b0;
    #1;
    obs_v = {oen, finished, iready, odata};
    exp_v = {3'b100, chunk(f1, 0)};
    checks++;
    if (obs_v !== exp_v) begin
      failures++; $display("FAIL ign_iready_low got=%h exp=%h", obs_v, exp_v);
    end
    step();
    oready = 1'b1;
    #1;
    obs_v = {oen, finished, iready, odata};
    exp_v = {3'b100, chunk(f1, 0)};
    checks++;
    if (obs_v !== exp_v) begin
      failures++; $display("FAIL ign_not_latched got=%h exp=%h", obs_v, exp_v);
    end
    step();
    #1;
    obs_v = {oen, finished, iready, odata};
    exp_v = {3'b111, chunk(f1, 1)};
    checks++;
    if (obs_v !== exp_v) begin
      failures++; $display("FAIL ign_last_chunk got=%h exp=%h", obs_v, exp_v);
    end
    step();
    ien = 1'b0; idata = '0;
    #1;
    obs_v = {oen, finished, iready, odata};
    exp_v = {3'b100, chunk(f2, 0)};
    checks++;
    if (obs_v !== exp_v) begin
      failures++; $display("FAIL ign_accept_on_last got=%h exp=%h", obs_v, exp_v);
    end
    step();
    step();
  endtask

  task automatic test_abort();
    ien = 1'b1; idata = f1;
    step();
    ien = 1'b0; idata = '0;
    fct = 1'b0;
    #1;
    obs_v = {oen, finished, iready, odata};
    exp_v = {3'b000, 64'h0};
    checks++;
    if (obs_v !== exp_v) begin
      failures++; $display("FAIL abort_fct_low got=%h exp=%h", obs_v, exp_v);
    end
    step();
    fct = 1'b1;
    #1;
    obs_v = {oen, finished, iready, odata};
    exp_v = {3'b001, 64'h0};
    checks++;
    if (obs_v !== exp_v) begin
      failures++; $display("FAIL abort_back_idle got=%h exp=%h", obs_v, exp_v);
    end
    ien = 1'b1; idata = f2;
    step();
    ien = 1'b0; idata = '0;
    #1;
    obs_v = {oen, finished, iready, odata};
    exp_v = {3'b100, chunk(f2, 0)};
    checks++;
    if (obs_v !== exp_v) begin
      failures++; $display("FAIL abort_new_frame got=%h exp=%h", obs_v, exp_v);
    end
    step();
    step();
  endtask

  task automatic test_reset_midframe();
    ien = 1'b1; idata = f1;
    step();
    ien = 1'b0; idata = '0;
    rst_n = 1'b0;
    step();
    obs_v = {oen, finished, iready, odata};
    exp_v = {3'b000, 64'h0};
    checks++;
    if (obs_v !== exp_v) begin
      failures++; $display("FAIL rst_mid_outputs got=%h exp=%h", obs_v, exp_v);
    end
    rst_n = 1'b1;
    #1;
    obs_v = {oen, finished, iready, odata};
    exp_v = {3'b001, 64'h0};
    checks++;
    if (obs_v !== exp_v) begin
      failures++; $display("FAIL rst_mid_idle got=%h exp=%h", obs_v, exp_v);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    f1 = {32'd1, 32'd2, 32'd4, 32'd8};
    f2 = {32'h8000_0000, 32'h4000_0000, 32'h2000_0000, 32'h1000_0000};
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_ignored_ien();
    test_abort();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
